// File: rtl/tdc_pkg.sv
// Shared constants for the input conditioner and its per-channel debouncer.
// The counter width helper keeps the terminal count representable.
package tdc_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_SIM    = 16;
  localparam int DEBOUNCE_BOARD  = 1000000;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain, stability counter, debounced level
// and single-cycle rise/fall strobes.
module debounce_channel
  import tdc_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync_out;
  logic                   w_differs;
  logic                   w_accept;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_differs  = w_sync_out ^ r_level;
  assign w_accept   = w_differs && (r_cnt == CNT_TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Any cycle that agrees with the current level restarts the stability run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= w_sync_out;
        r_cnt   <= '0;
        r_rise  <= w_sync_out;
        r_fall  <= ~w_sync_out;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Board button front end: N_IN independent debounce channels plus a combined
// change strobe for the downstream LED test logic.
module input_conditioner
  import tdc_pkg::*;
#(
  parameter int N_IN            = 5,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] btn_raw,
  output logic [N_IN-1:0] btn_level,
  output logic [N_IN-1:0] btn_rise,
  output logic [N_IN-1:0] btn_fall,
  output logic            any_change
);

  for (genvar g = 0; g < N_IN; g++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (btn_raw[g]),
      .o_level (btn_level[g]),
      .o_rise  (btn_rise[g]),
      .o_fall  (btn_fall[g])
    );
  end

  assign any_change = |(btn_rise | btn_fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// pin activity, all compared against a sliding-window reference model.
module tb_input_conditioner;

  localparam int N    = 5;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LAT  = SYNC + DEB;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic         any_change;

  int n_cmp = 0;
  int n_err = 0;

  input_conditioner #(
    .N_IN            (N),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .btn_fall   (btn_fall),
    .any_change (any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the value seen at an edge is the pin sampled SYNC edges earlier;
  // the level flips when the last DEB seen values all disagree with it.
  logic [N-1:0] m_level, m_rise, m_fall;
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_win[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] s, nl, r, f;
    bit all_diff;
    if (!rst_n) begin
      m_pipe.delete();
      repeat (SYNC) m_pipe.push_back('0);
      m_win.delete();
      m_level <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(btn_raw);
      m_win.push_back(s);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      nl = m_level;
      r  = '0;
      f  = '0;
      if (m_win.size() == DEB) begin
        for (int c = 0; c < N; c++) begin
          all_diff = 1'b1;
          foreach (m_win[k]) if (m_win[k][c] == m_level[c]) all_diff = 1'b0;
          if (all_diff) begin
            nl[c] = ~m_level[c];
            r[c]  = nl[c];
            f[c]  = ~nl[c];
          end
        end
      end
      m_level <= nl;
      m_rise  <= r;
      m_fall  <= f;
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    int rise_edge = -1;
    int any_cnt   = 0;
    btn_raw = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !== '0) begin
        n_err++;
        $display("FAIL reset_hold: got lvl=%b rise=%b fall=%b any=%b want all 0",
                 btn_level, btn_rise, btn_fall, any_change);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        $display("FAIL reset_model e%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 e, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
      if (btn_rise == 5'b11111 && rise_edge < 0) rise_edge = e;
      if (any_change) any_cnt++;
    end
    n_cmp++;
    if (rise_edge != LAT) begin
      n_err++;
      $display("FAIL reset_rise_edge: got %0d want %0d", rise_edge, LAT);
    end
    n_cmp++;
    if (any_cnt != 1 || btn_level !== 5'b11111) begin
      n_err++;
      $display("FAIL reset_final: got any_cnt=%0d lvl=%b want 1 11111", any_cnt, btn_level);
    end
    btn_raw = '0;
    idle(40);
  endtask

  task automatic test_clean_press();
    int rise_edge = -1;
    int rise_cnt  = 0;
    int fall_cnt  = 0;
    btn_raw = 5'b00001;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        $display("FAIL press_model e%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 e, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
      if (btn_rise[0]) begin
        rise_cnt++;
        if (rise_edge < 0) rise_edge = e;
      end
      if (btn_fall != '0) fall_cnt++;
    end
    n_cmp++;
    if (rise_edge != LAT || rise_cnt != 1 || fall_cnt != 0 || btn_level[0] !== 1'b1) begin
      n_err++;
      $display("FAIL press_summary: got edge=%0d rises=%0d falls=%0d lvl0=%b want %0d 1 0 1",
               rise_edge, rise_cnt, fall_cnt, btn_level[0], LAT);
    end
    btn_raw = '0;
    idle(40);
  endtask

  task automatic test_glitch(input int width, input int exp_rises);
    int rise_edge = -1;
    int rise_cnt  = 0;
    int fall_cnt  = 0;
    btn_raw = 5'b00010;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        $display("FAIL glitch%0d_model e%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 width, e, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
      if (btn_rise[1]) begin
        rise_cnt++;
        if (rise_edge < 0) rise_edge = e;
      end
      if (btn_fall[1]) fall_cnt++;
      if (e == width) btn_raw = '0;
    end
    n_cmp++;
    if (rise_cnt != exp_rises || fall_cnt != exp_rises || btn_level[1] !== 1'b0) begin
      n_err++;
      $display("FAIL glitch%0d_count: got rises=%0d falls=%0d lvl1=%b want %0d %0d 0",
               width, rise_cnt, fall_cnt, btn_level[1], exp_rises, exp_rises);
    end
    if (exp_rises != 0) begin
      n_cmp++;
      if (rise_edge != LAT) begin
        n_err++;
        $display("FAIL glitch%0d_edge: got %0d want %0d", width, rise_edge, LAT);
      end
    end
    idle(5);
  endtask

  task automatic test_bounce();
    int rise_edge = -1;
    int rise_cnt  = 0;
    int fall_cnt  = 0;
    btn_raw = 5'b00100;
    for (int e = 1; e <= 70; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        $display("FAIL bounce_model e%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 e, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
      if (btn_rise[2]) begin
        rise_cnt++;
        if (rise_edge < 0) rise_edge = e;
      end
      if (btn_fall[2]) fall_cnt++;
      btn_raw[2] = (e >= 30) ? 1'b1 : (((e / 3) % 2) == 0);
    end
    n_cmp++;
    if (rise_cnt != 1 || fall_cnt != 0 || rise_edge != 30 + LAT || btn_level[2] !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_summary: got rises=%0d falls=%0d edge=%0d lvl2=%b want 1 0 %0d 1",
               rise_cnt, fall_cnt, rise_edge, btn_level[2], 30 + LAT);
    end
    btn_raw = '0;
    idle(40);
  endtask

  task automatic test_simultaneous();
    int pulse_cycles = 0;
    int pulse_edge   = -1;
    logic [N-1:0] seen = '0;
    btn_raw = 5'b11000;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        $display("FAIL simul_model e%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 e, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
      if (btn_rise != '0) begin
        pulse_cycles++;
        pulse_edge = e;
        seen = btn_rise;
      end
    end
    n_cmp++;
    if (pulse_cycles != 1 || pulse_edge != LAT || seen !== 5'b11000) begin
      n_err++;
      $display("FAIL simul_summary: got cycles=%0d edge=%0d rise=%b want 1 %0d 11000",
               pulse_cycles, pulse_edge, seen, LAT);
    end
    btn_raw = '0;
    idle(40);
  endtask

  task automatic test_reset_mid();
    int early     = 0;
    int rise_edge = -1;
    int rise_cnt  = 0;
    btn_raw = 5'b00001;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (btn_rise != '0 || btn_fall != '0) early++;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !== '0) begin
        n_err++;
        $display("FAIL midrst_hold: got lvl=%b rise=%b fall=%b any=%b want all 0",
                 btn_level, btn_rise, btn_fall, any_change);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        $display("FAIL midrst_model e%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                 e, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
      if (btn_rise[0]) begin
        rise_cnt++;
        if (rise_edge < 0) rise_edge = e;
      end
    end
    n_cmp++;
    if (early != 0 || rise_cnt != 1 || rise_edge != LAT) begin
      n_err++;
      $display("FAIL midrst_summary: got early=%0d rises=%0d edge=%0d want 0 1 %0d",
               early, rise_cnt, rise_edge, LAT);
    end
    btn_raw = '0;
    idle(40);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int e = 0; e < 2000; e++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, any_change} !==
          {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
        n_err++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_model c%0d: got lvl=%b rise=%b fall=%b any=%b want lvl=%b rise=%b fall=%b",
                   e, btn_level, btn_rise, btn_fall, any_change, m_level, m_rise, m_fall);
      end
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 11) == 0) btn_raw[c] = ~btn_raw[c];
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    btn_raw = '0;
    #2 rst_n = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch(DEB - 1, 0);
    test_glitch(DEB, 1);
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
